// File: rtl/video_sync_if.sv
// Timing bundle between the sync generator and the graphics/cartridge blocks.
// The generator owns every signal except the interrupt acknowledge.
interface video_sync_if;
  logic       VBKACK_b;
  logic       MCKR;
  logic       SC_1H, SC_2H, SC_4H, SC_8H, SC_16H, SC_32H, SC_64H, SC_128H, SC_256H;
  logic       SC_1V, SC_2V, SC_4V, SC_8V, SC_16V, SC_32V, SC_64V, SC_128V;
  logic       HBLANK_b, HSYNC, VBLANK_b, VSYNC, VBKINT_b;
  logic       PFHST_b, BUFCLR_b, LMPD_b, NXL_b, NXL_b_star;
  logic [2:0] VRAC;

  modport master (
    input  VBKACK_b,
    output MCKR,
    output SC_1H, SC_2H, SC_4H, SC_8H, SC_16H, SC_32H, SC_64H, SC_128H, SC_256H,
    output SC_1V, SC_2V, SC_4V, SC_8V, SC_16V, SC_32V, SC_64V, SC_128V,
    output HBLANK_b, HSYNC, VBLANK_b, VSYNC, VBKINT_b,
    output PFHST_b, BUFCLR_b, LMPD_b, NXL_b, NXL_b_star, VRAC
  );

  modport slave (
    output VBKACK_b,
    input  MCKR,
    input  SC_1H, SC_2H, SC_4H, SC_8H, SC_16H, SC_32H, SC_64H, SC_128H, SC_256H,
    input  SC_1V, SC_2V, SC_4V, SC_8V, SC_16V, SC_32V, SC_64V, SC_128V,
    input  HBLANK_b, HSYNC, VBLANK_b, VSYNC, VBKINT_b,
    input  PFHST_b, BUFCLR_b, LMPD_b, NXL_b, NXL_b_star, VRAC
  );
endinterface

// File: rtl/video_sync_gen.sv
// Divides clk100 by 14 into MCKR and runs the 456x262 raster counters.
// All decodes are registered on the MCKR-rise edge from the next H/V values.
module video_sync_gen (
  input  logic          clk100,
  input  logic          reset,
  video_sync_if.master  vs
);
  localparam logic [3:0] CNT_LAST = 4'd13;
  localparam logic [3:0] CNT_TICK = 4'd6;
  localparam logic [3:0] CNT_HIGH = 4'd7;
  localparam logic [8:0] H_LAST   = 9'd455;
  localparam logic [8:0] V_LAST   = 9'd261;

  logic [3:0] cnt_q, cnt_d;
  logic [8:0] h_q, h_d;
  logic [8:0] v_q, v_d;
  logic       tick;

  logic mckr_q, hblank_b_q, hsync_q, vblank_b_q, vsync_q, vbkint_b_q;
  logic pfhst_b_q, bufclr_b_q, lmpd_b_q, nxl_b_q, nxl_b_star_q;

  always_comb begin
    tick  = (cnt_q == CNT_TICK);
    cnt_d = (cnt_q == CNT_LAST) ? 4'd0 : cnt_q + 4'd1;
    h_d   = h_q;
    v_d   = v_q;
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 9'd1;
      end else begin
        h_d = h_q + 9'd1;
      end
    end
  end

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      h_q          <= '0;
      v_q          <= '0;
      mckr_q       <= 1'b0;
      hblank_b_q   <= 1'b1;
      hsync_q      <= 1'b0;
      vblank_b_q   <= 1'b1;
      vsync_q      <= 1'b0;
      vbkint_b_q   <= 1'b1;
      pfhst_b_q    <= 1'b1;
      bufclr_b_q   <= 1'b1;
      lmpd_b_q     <= 1'b1;
      nxl_b_q      <= 1'b1;
      nxl_b_star_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      h_q    <= h_d;
      v_q    <= v_d;
      mckr_q <= (cnt_d >= CNT_HIGH);
      if (tick) begin
        hblank_b_q   <= !(h_d >= 9'd336);
        hsync_q      <= (h_d >= 9'd368) && (h_d <= 9'd399);
        vblank_b_q   <= !(v_d >= 9'd240);
        vsync_q      <= (v_d >= 9'd244) && (v_d <= 9'd246);
        pfhst_b_q    <= !(h_d == 9'd440);
        bufclr_b_q   <= !((h_d >= 9'd344) && (h_d <= 9'd351));
        lmpd_b_q     <= !(h_d[2:0] == 3'd7);
        nxl_b_q      <= !(h_d == 9'd455);
        nxl_b_star_q <= !(h_d == 9'd454);
      end
      // A fresh request at the top of vblank beats a simultaneous acknowledge.
      if (tick && (h_d == 9'd0) && (v_d == 9'd240)) vbkint_b_q <= 1'b0;
      else if (!vs.VBKACK_b)                         vbkint_b_q <= 1'b1;
    end
  end

  assign vs.MCKR    = mckr_q;
  assign vs.SC_1H   = h_q[0];
  assign vs.SC_2H   = h_q[1];
  assign vs.SC_4H   = h_q[2];
  assign vs.SC_8H   = h_q[3];
  assign vs.SC_16H  = h_q[4];
  assign vs.SC_32H  = h_q[5];
  assign vs.SC_64H  = h_q[6];
  assign vs.SC_128H = h_q[7];
  assign vs.SC_256H = h_q[8];
  assign vs.SC_1V   = v_q[0];
  assign vs.SC_2V   = v_q[1];
  assign vs.SC_4V   = v_q[2];
  assign vs.SC_8V   = v_q[3];
  assign vs.SC_16V  = v_q[4];
  assign vs.SC_32V  = v_q[5];
  assign vs.SC_64V  = v_q[6];
  assign vs.SC_128V = v_q[7];
  assign vs.VRAC    = h_q[3:1];

  assign vs.HBLANK_b   = hblank_b_q;
  assign vs.HSYNC      = hsync_q;
  assign vs.VBLANK_b   = vblank_b_q;
  assign vs.VSYNC      = vsync_q;
  assign vs.VBKINT_b   = vbkint_b_q;
  assign vs.PFHST_b    = pfhst_b_q;
  assign vs.BUFCLR_b   = bufclr_b_q;
  assign vs.LMPD_b     = lmpd_b_q;
  assign vs.NXL_b      = nxl_b_q;
  assign vs.NXL_b_star = nxl_b_star_q;

  // V[8] only feeds the wrap and decodes; it has no pin of its own.
endmodule

// File: tb/tb_video_sync_gen.sv
// Bench for video_sync_gen: cycle-level reference model feeding a scoreboard,
// plus directed checks of divider, line decodes, vertical boundaries and interrupt.
module tb_video_sync_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  video_sync_if vif();
  video_sync_gen dut (.clk100(clk), .reset(reset), .vs(vif));

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [8:0]  sc_h;
  logic [7:0]  sc_v;
  logic [30:0] obs;
  assign sc_h = {vif.SC_256H, vif.SC_128H, vif.SC_64H, vif.SC_32H, vif.SC_16H,
                 vif.SC_8H, vif.SC_4H, vif.SC_2H, vif.SC_1H};
  assign sc_v = {vif.SC_128V, vif.SC_64V, vif.SC_32V, vif.SC_16V,
                 vif.SC_8V, vif.SC_4V, vif.SC_2V, vif.SC_1V};
  assign obs  = {vif.MCKR, sc_h, sc_v, vif.HBLANK_b, vif.HSYNC, vif.VBLANK_b, vif.VSYNC,
                 vif.VBKINT_b, vif.PFHST_b, vif.BUFCLR_b, vif.LMPD_b, vif.NXL_b,
                 vif.NXL_b_star, vif.VRAC};

  localparam logic [30:0] RST_VEC = {1'b0, 9'd0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0,
                                     1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0};

  // Reference model, written from the raster definition rather than the RTL structure.
  logic [3:0] mcnt;
  logic [8:0] mh, mv;
  logic       mvbk, mtick;
  logic [30:0] sb[$];

  function automatic logic [30:0] expv();
    return {mcnt >= 4'd7, mh, mv[7:0],
            !(mh >= 9'd336), (mh >= 9'd368 && mh <= 9'd399),
            !(mv >= 9'd240), (mv >= 9'd244 && mv <= 9'd246),
            mvbk, !(mh == 9'd440), !(mh >= 9'd344 && mh <= 9'd351),
            !(mh[2:0] == 3'd7), !(mh == 9'd455), !(mh == 9'd454), mh[3:1]};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mcnt = 0; mh = 0; mv = 0; mvbk = 1'b1;
    end else begin
      mtick = (mcnt == 4'd6);
      mcnt  = (mcnt == 4'd13) ? 4'd0 : mcnt + 4'd1;
      if (mtick) begin
        if (mh == 9'd455) begin
          mh = 0;
          mv = (mv == 9'd261) ? 9'd0 : mv + 9'd1;
        end else mh = mh + 9'd1;
      end
      if (mtick && mh == 9'd0 && mv == 9'd240) mvbk = 1'b0;
      else if (!vif.VBKACK_b)                  mvbk = 1'b1;
    end
    sb.delete();
    sb.push_back(expv());
  end

  always @(negedge clk) begin
    logic [30:0] e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (chk_en) chk("outs", {1'b0, obs}, {1'b0, e});
    end
  end

  task automatic wait_hv(input string tag, input int h, input int v, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (sc_h == h[8:0] && sc_v == v[7:0]) found = 1'b1;
    end
    chk(tag, {31'd0, found}, 32'd1);
  endtask

  // Jump the vertical counter so far-off lines are reachable in a short run.
  task automatic set_v(input logic [8:0] nv);
    bit ok = 1'b0;
    for (int i = 0; i < 7000 && !ok; i++) begin
      @(negedge clk);
      if (sc_h < 9'd400) ok = 1'b1;
    end
    chk("setv_window", {31'd0, ok}, 32'd1);
    chk_en = 1'b0;
    force dut.v_q = nv;
    mv = nv;
    @(negedge clk);
    release dut.v_q;
    repeat (15) @(negedge clk);
    chk_en = 1'b1;
  endtask

  task automatic chk_startup(input string p);
    int k;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!vif.MCKR && k < 20);
    chk({p, "_rise"}, k, 7);
    chk({p, "_h1"}, {23'd0, sc_h}, 1);
    k = 0;
    do begin @(posedge clk); #1; k++; end while (vif.MCKR && k < 20);
    chk({p, "_high"}, k, 7);
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!vif.MCKR && k < 20);
    chk({p, "_low"}, k, 7);
  endtask

  initial begin
    int hs, bc, pf, nx, nxs, lm, hb, vsc;
    vif.VBKACK_b = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_vals", {1'b0, obs}, {1'b0, RST_VEC});
    reset = 1'b0;
    chk_startup("pwr");

    // One full line of horizontal decodes, measured in clk100 cycles.
    wait_hv("line_start", 0, 1, 7000);
    hs = 0; bc = 0; pf = 0; nx = 0; nxs = 0; lm = 0; hb = 0;
    for (int i = 0; i < 6384; i++) begin
      hs  += int'(vif.HSYNC);
      bc  += int'(!vif.BUFCLR_b);
      pf  += int'(!vif.PFHST_b);
      nx  += int'(!vif.NXL_b);
      nxs += int'(!vif.NXL_b_star);
      lm  += int'(!vif.LMPD_b);
      hb  += int'(!vif.HBLANK_b);
      @(negedge clk);
    end
    chk("line_len_h", {23'd0, sc_h}, 0);
    chk("line_len_v", {24'd0, sc_v}, 2);
    chk("hsync_cyc", hs, 448);
    chk("bufclr_cyc", bc, 112);
    chk("pfhst_cyc", pf, 14);
    chk("nxl_cyc", nx, 14);
    chk("nxls_cyc", nxs, 14);
    chk("lmpd_cyc", lm, 798);
    chk("hblank_cyc", hb, 1680);

    // Interrupt request, hold and acknowledge.
    set_v(9'd239);
    wait_hv("to_vbk", 0, 240, 7000);
    chk("vbk_set", {31'd0, vif.VBKINT_b}, 0);
    chk("vblank_fall", {31'd0, vif.VBLANK_b}, 0);
    repeat (20) @(negedge clk);
    chk("vbk_hold", {31'd0, vif.VBKINT_b}, 0);
    vif.VBKACK_b = 1'b0;
    @(negedge clk);
    vif.VBKACK_b = 1'b1;
    chk("vbk_ack", {31'd0, vif.VBKINT_b}, 1);

    // Acknowledge held across the setting tick: the request must still land.
    set_v(9'd239);
    wait_hv("to_455", 455, 239, 7000);
    vif.VBKACK_b = 1'b0;
    wait_hv("to_vbk2", 0, 240, 20);
    chk("vbk_coin", {31'd0, vif.VBKINT_b}, 0);
    @(negedge clk);
    chk("vbk_clr", {31'd0, vif.VBKINT_b}, 1);
    vif.VBKACK_b = 1'b1;

    // Vertical sync window 244..246.
    set_v(9'd243);
    wait_hv("to_vs", 0, 244, 7000);
    vsc = 0;
    for (int i = 0; i < 19152; i++) begin
      vsc += int'(vif.VSYNC);
      @(negedge clk);
    end
    chk("vsync_cyc", vsc, 19152);
    chk("vsync_end", {31'd0, vif.VSYNC}, 0);
    chk("vsync_v", {24'd0, sc_v}, 247);

    set_v(9'd261);
    wait_hv("v_wrap", 0, 0, 7000);
    chk("wrap_vblank", {31'd0, vif.VBLANK_b}, 1);

    set_v(9'd255);
    wait_hv("v256", 0, 0, 7000);
    chk("v256_vblank", {31'd0, vif.VBLANK_b}, 0);

    // Asynchronous reset in the middle of a line.
    set_v(9'd100);
    wait_hv("to_300", 300, 100, 7000);
    #3 reset = 1'b1;
    #1 chk("rst_async", {1'b0, obs}, {1'b0, RST_VEC});
    @(negedge clk);
    reset = 1'b0;
    chk_startup("mid");
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
